mesh_pe_ni: RTL

- Clocked network interface between one synchronous processing element (PE) and its mesh router's PE port.
- Tx side: takes PE words via valid/ready, packs them into WIDTH_packet-bit packets, and drives them onto the router's PE-input channel (4-phase bundled-data req/ack).
- Rx side: accepts packets from the router's PE-output channel (4-phase bundled-data), buffers them in a small FIFO, and presents them to the PE via valid/ready.
- One instance per mesh node (NODE_ID 1..15).

---
 rtl/mesh_pe_ni_if.sv | 45 ++++
 rtl/mesh_pe_ni.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mesh_pe_ni_if.sv
// mesh_pe_ni_if: groups every non-clock signal of the PE network interface.
//   PE tx side : tx_valid, tx_ready, tx_dst, tx_payload, tx_err
//   router out : net_out_req, net_out_ack, net_out_data (4-phase bundled data)
//   router in  : net_in_req, net_in_ack, net_in_data   (4-phase bundled data)
//   PE rx side : rx_valid, rx_ready, rx_src, rx_payload
//   status     : tx_count, rx_count
// The slave modport is the NI itself; the master modport is its surroundings
// (the PE plus the router's PE port).
interface mesh_pe_ni_if #(
    parameter int WIDTH_packet = 57
);
    logic                    tx_valid;
    logic                    tx_ready;
    logic [3:0]              tx_dst;
    logic [WIDTH_packet-9:0] tx_payload;
    logic                    tx_err;

    logic                    net_out_req;
    logic                    net_out_ack;
    logic [WIDTH_packet-1:0] net_out_data;

    logic                    net_in_req;
    logic                    net_in_ack;
    logic [WIDTH_packet-1:0] net_in_data;

    logic                    rx_valid;
    logic                    rx_ready;
    logic [3:0]              rx_src;
    logic [WIDTH_packet-9:0] rx_payload;

    logic [15:0]             tx_count;
    logic [15:0]             rx_count;

    modport slave (
        input  tx_valid, tx_dst, tx_payload, net_out_ack, net_in_req, net_in_data, rx_ready,
        output tx_ready, tx_err, net_out_req, net_out_data, net_in_ack,
               rx_valid, rx_src, rx_payload, tx_count, rx_count
    );

    modport master (
        output tx_valid, tx_dst, tx_payload, net_out_ack, net_in_req, net_in_data, rx_ready,
        input  tx_ready, tx_err, net_out_req, net_out_data, net_in_ack,
               rx_valid, rx_src, rx_payload, tx_count, rx_count
    );
endinterface

// File: rtl/mesh_pe_ni.sv
// mesh_pe_ni: network interface between a synchronous PE and the PE port of
// its mesh router.
//   clk, rst_n : single clock, synchronous active-low reset
//   ni (slave) : PE tx valid/ready, router 4-phase out/in channels,
//                PE rx valid/ready, packet counters
// Tx packs {dst, NODE_ID, payload} and runs a 4-phase req/ack toward the
// router. Rx takes 4-phase packets from the router into a small FWFT FIFO;
// a full FIFO withholds ack, which is the only rx backpressure.
module mesh_pe_ni #(
    parameter int         WIDTH_packet = 57,
    parameter logic [3:0] NODE_ID      = 4'd1,
    parameter int         RX_DEPTH     = 4,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    mesh_pe_ni_if.slave ni
);
    localparam int PAY_W   = WIDTH_packet - 8;
    localparam int ENTRY_W = WIDTH_packet - 4;   // {src, payload}; dst is dropped on rx
    localparam int PTR_W   = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_t;
    typedef enum logic       {R_IDLE, R_ACK}        rx_state_t;

    // ------------------------------------------------------------------
    // Synchronizers for the asynchronous handshake inputs
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   ack_s;
    logic                   req_s;

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_sync <= '0;
            req_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ni.net_out_ack};
            req_sync <= {req_sync[SYNC_STAGES-2:0], ni.net_in_req};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign req_s = req_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Tx FSM
    // ------------------------------------------------------------------
    tx_state_t               tx_state;
    logic                    tx_ready_q;
    logic                    tx_err_q;
    logic                    out_req_q;
    logic [WIDTH_packet-1:0] out_data_q;
    logic [15:0]             tx_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state   <= T_IDLE;
            tx_ready_q <= 1'b0;
            tx_err_q   <= 1'b0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            tx_count_q <= '0;
        end else begin
            tx_err_q <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    tx_ready_q <= 1'b1;
                    // Accept only on a cycle where tx_ready was already visible.
                    if (ni.tx_valid && tx_ready_q) begin
                        if (ni.tx_dst == 4'd0) begin
                            tx_err_q <= 1'b1;
                        end else begin
                            out_data_q <= {ni.tx_dst, NODE_ID, ni.tx_payload};
                            out_req_q  <= 1'b1;
                            tx_ready_q <= 1'b0;
                            tx_state   <= T_REQ;
                        end
                    end
                end
                T_REQ: begin
                    if (ack_s) begin
                        out_req_q <= 1'b0;
                        tx_state  <= T_REL;
                    end
                end
                T_REL: begin
                    // Data stays held until the router has released ack.
                    if (!ack_s) begin
                        tx_count_q <= tx_count_q + 16'd1;
                        tx_ready_q <= 1'b1;
                        tx_state   <= T_IDLE;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    assign ni.tx_ready     = tx_ready_q;
    assign ni.tx_err       = tx_err_q;
    assign ni.net_out_req  = out_req_q;
    assign ni.net_out_data = out_data_q;
    assign ni.tx_count     = tx_count_q;

    // ------------------------------------------------------------------
    // Rx FSM and FIFO
    // ------------------------------------------------------------------
    rx_state_t        rx_state;
    logic             in_ack_q;
    logic [15:0]      rx_count_q;
    logic [ENTRY_W-1:0] mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fill;
    logic             full;
    logic             rx_valid;
    logic             push;
    logic             pop;
    logic [ENTRY_W-1:0] head;
    logic             unused_dst;

    // Push looks at the pre-pop full flag, so a push into a full FIFO waits
    // one cycle even if the PE pops in the same cycle.
    assign full     = (fill == (PTR_W+1)'(RX_DEPTH));
    assign rx_valid = (fill != '0);
    assign push     = (rx_state == R_IDLE) && req_s && !full;
    assign pop      = rx_valid && ni.rx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state   <= R_IDLE;
            in_ack_q   <= 1'b0;
            rx_count_q <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (push) begin
                        rx_count_q <= rx_count_q + 16'd1;
                        in_ack_q   <= 1'b1;
                        rx_state   <= R_ACK;
                    end
                end
                R_ACK: begin
                    if (!req_s) begin
                        in_ack_q <= 1'b0;
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and fill count, and the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ni.net_in_data[ENTRY_W-1:0];
    end

    assign head          = mem[rd_ptr];
    assign ni.net_in_ack = in_ack_q;
    assign ni.rx_valid   = rx_valid;
    assign ni.rx_src     = rx_valid ? head[ENTRY_W-1 -: 4] : 4'd0;
    assign ni.rx_payload = rx_valid ? head[PAY_W-1:0] : '0;
    assign ni.rx_count   = rx_count_q;

    // Destination field of incoming packets is intentionally ignored.
    assign unused_dst = &{1'b0, ni.net_in_data[WIDTH_packet-1 -: 4]};
endmodule
